gbt_rx_header_aligner: RTL and testbench
========================================

GBT_RX_HEADER_ALIGNER -- requirements
Module: gbt_rx_header_aligner

Interface
REQ-001 The block SHALL have parameter GOOD_HEADERS, default 64: consecutive valid headers needed to declare lock.
REQ-002 The block SHALL have parameter BAD_HEADERS, default 4: consecutive invalid headers needed to drop lock.
REQ-003 The block SHALL have parameter SLIP_WAIT, default 32: idle cycles after each slip pulse.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; port rx_wordclk, input, 1, the MGT RX word clock.
REQ-005 Port rx_reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port rx_is_lockedtodata, input, 1, CDR lock status from the transceiver channel.
REQ-007 Port rx_parallel_data, input, 20, raw RX word from the transceiver channel.
REQ-008 Port rx_pma_clkslip, output, 1, one-cycle slip request to the transceiver channel.
REQ-009 Port rx_data_out, output, 20, registered copy of rx_parallel_data.
REQ-010 Port frame_start, output, 1, marks word 0 of a 6-word frame on rx_data_out.
REQ-011 Port header_locked, output, 1, frame alignment achieved.
REQ-012 Port header_is_data, output, 1, the current frame header is 4'b0101.
REQ-013 Port slip_count, output, 5, number of slips issued since the last search start, modulo 20.

Function
REQ-014 Header SHALL be rx_parallel_data[19:16]: 4'b0101 (data) and 4'b0110 (idle) are valid; every other value is invalid.
REQ-015 rx_data_out SHALL equal rx_parallel_data delayed by exactly 1 cycle; frame_start, header_is_data and header_locked SHALL be aligned to rx_data_out.
REQ-016 States SHALL be IDLE, SEARCH, SLIP_WAIT, CONFIRM and LOCKED.
REQ-017 IDLE: wait for rx_is_lockedtodata=1, then go to SEARCH with the word counter cleared and slip_count=0.
REQ-018 SEARCH: check every word; on the first valid header, set word_cnt so that this word is index 0, set good_cnt=1 and go to CONFIRM.
REQ-019 SEARCH: after 6 consecutive words with no valid header, pulse rx_pma_clkslip for 1 cycle, increment slip_count (19 wraps to 0) and go to SLIP_WAIT.
REQ-020 SLIP_WAIT: hold for SLIP_WAIT cycles with no header checks, then return to SEARCH with the miss counter cleared.
REQ-021 word_cnt SHALL run 0..5 and wrap; headers are checked only at word_cnt=0 in CONFIRM and LOCKED.
REQ-022 CONFIRM: a valid header increments good_cnt; when good_cnt reaches GOOD_HEADERS, go to LOCKED.
REQ-023 CONFIRM: an invalid header SHALL return the FSM to SEARCH with no slip, resuming the check at the next word.
REQ-024 LOCKED: an invalid header increments bad_cnt and a valid header clears it; when bad_cnt reaches BAD_HEADERS, go to SEARCH and drop header_locked in the same cycle.
REQ-025 frame_start SHALL be 1 only in LOCKED at word_cnt=0; header_is_data is updated at each frame_start.
REQ-026 rx_is_lockedtodata=0 in any state SHALL force IDLE on the next edge and clear all counters; this has priority over any same-cycle header event.
REQ-027 rx_pma_clkslip SHALL never be asserted in two consecutive cycles, nor outside the SEARCH-to-SLIP_WAIT transition.

Reset
REQ-028 Reset SHALL be asynchronous on rx_reset_n=0 and released synchronously to rx_wordclk.
REQ-029 Reset SHALL give: state=IDLE; rx_pma_clkslip, frame_start, header_locked and header_is_data all 0; rx_data_out=0; slip_count=0; all internal counters 0.
REQ-030 Reset mid-slip SHALL terminate the pulse immediately.

Structure
REQ-031 A shared package gbt_rx_align_pkg SHALL hold the state enum, the header constants (4'b0101, 4'b0110) and WORDS_PER_FRAME=6.
REQ-032 Everything is one module; no sub-module is needed.
REQ-033 One instance SHALL serve one channel; the 3-channel wrapper instantiates it 3 times on slices of the 60-bit bus.

Verification
REQ-034 Lock from reset: rx_is_lockedtodata=1 with headers 4'b0101 every 6th word at offset 2 -> header_locked=1 after 64 frames; frame_start coincides with those words; zero slips.
REQ-035 Bit misalignment: stream correct only after 3 slips -> exactly 3 one-cycle rx_pma_clkslip pulses each followed by ≥32 quiet cycles; slip_count=3; then lock.
REQ-036 False header: a single valid header at a wrong offset followed by a mismatch in CONFIRM -> return to SEARCH with no slip, then lock at the true offset.
REQ-037 Lock loss: in LOCKED inject 3 bad headers then 1 good, then 4 bad -> lock is kept after the first burst; header_locked falls on the 4th consecutive bad header.
REQ-038 Async events: drop rx_is_lockedtodata in LOCKED -> IDLE next cycle with outputs cleared; assert rx_reset_n=0 during a slip pulse -> rx_pma_clkslip=0 immediately.
REQ-039 Wrap: 20 slips with no valid header -> slip_count wraps 19 to 0 and searching continues.

Source files
------------

// File: rtl/gbt_rx_align_pkg.sv
// Shared state encoding, header constants and frame geometry for the
// GBT RX header aligner.
package gbt_rx_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_CONFIRM,
    ST_LOCKED
  } align_state_e;

  localparam logic [3:0] HDR_DATA        = 4'b0101;
  localparam logic [3:0] HDR_IDLE        = 4'b0110;
  localparam int         WORDS_PER_FRAME = 6;
  localparam int         SLIP_COUNT_MOD  = 20;

  function automatic logic header_valid(input logic [3:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_IDLE);
  endfunction

endpackage

// File: rtl/gbt_rx_header_aligner.sv
// Per-channel GBT frame aligner: hunts for the 4-bit frame header, slips the
// transceiver word boundary when none is found, and tracks lock once found.
module gbt_rx_header_aligner
  import gbt_rx_align_pkg::*;
#(
  parameter int GOOD_HEADERS = 64,
  parameter int BAD_HEADERS  = 4,
  parameter int SLIP_WAIT    = 32
) (
  input  logic        rx_wordclk,
  input  logic        rx_reset_n,
  input  logic        rx_is_lockedtodata,
  input  logic [19:0] rx_parallel_data,
  output logic        rx_pma_clkslip,
  output logic [19:0] rx_data_out,
  output logic        frame_start,
  output logic        header_locked,
  output logic        header_is_data,
  output logic [4:0]  slip_count
);

  localparam int         GW        = $clog2(GOOD_HEADERS + 1);
  localparam int         BW        = $clog2(BAD_HEADERS + 1);
  localparam int         WW        = $clog2(SLIP_WAIT + 1);
  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_FRAME - 1);
  localparam logic [4:0] LAST_SLIP = 5'(SLIP_COUNT_MOD - 1);

  align_state_e  state, state_nxt;
  logic [2:0]    word_cnt;
  logic [2:0]    miss_cnt;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;
  logic [WW-1:0] wait_cnt;

  logic hdr_ok, frame_word, miss_done, wait_done, good_done, bad_done;
  logic slip_req, frame_start_nxt, locked_nxt;

  assign hdr_ok     = header_valid(rx_parallel_data[19:16]);
  assign frame_word = (word_cnt == 3'd0);
  assign miss_done  = (miss_cnt == LAST_WORD);
  assign wait_done  = (wait_cnt == WW'(SLIP_WAIT - 1));
  assign good_done  = (good_cnt == GW'(GOOD_HEADERS - 1));
  assign bad_done   = (bad_cnt == BW'(BAD_HEADERS - 1));

  always_ff @(posedge rx_wordclk or negedge rx_reset_n) begin
    if (!rx_reset_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Losing CDR lock overrides every header decision made in the same cycle.
  always_comb begin
    state_nxt = state;
    if (!rx_is_lockedtodata) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      state_nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (hdr_ok)         state_nxt = ST_CONFIRM;
          else if (miss_done) state_nxt = ST_SLIP_WAIT;
        end
        ST_SLIP_WAIT: if (wait_done) state_nxt = ST_SEARCH;
        ST_CONFIRM: begin
          if (frame_word) begin
            if (!hdr_ok)        state_nxt = ST_SEARCH;
            else if (good_done) state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: if (frame_word && !hdr_ok && bad_done) state_nxt = ST_SEARCH;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    slip_req        = (state == ST_SEARCH) && (state_nxt == ST_SLIP_WAIT);
    locked_nxt      = (state_nxt == ST_LOCKED);
    frame_start_nxt = locked_nxt && frame_word;
  end

  always_ff @(posedge rx_wordclk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      word_cnt   <= '0;
      miss_cnt   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      wait_cnt   <= '0;
      slip_count <= '0;
    end else if (!rx_is_lockedtodata || state == ST_IDLE) begin
      word_cnt   <= '0;
      miss_cnt   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      wait_cnt   <= '0;
      slip_count <= '0;
    end else begin
      word_cnt <= (word_cnt == LAST_WORD) ? 3'd0 : word_cnt + 3'd1;
      unique case (state)
        ST_SEARCH: begin
          if (hdr_ok) begin
            // The word just seen is index 0, so the next one is index 1.
            word_cnt <= 3'd1;
            good_cnt <= GW'(1);
            bad_cnt  <= '0;
            miss_cnt <= '0;
          end else if (miss_done) begin
            miss_cnt   <= '0;
            wait_cnt   <= '0;
            slip_count <= (slip_count == LAST_SLIP) ? 5'd0 : slip_count + 5'd1;
          end else begin
            miss_cnt <= miss_cnt + 3'd1;
          end
        end
        ST_SLIP_WAIT: begin
          wait_cnt <= wait_done ? '0 : wait_cnt + WW'(1);
          miss_cnt <= '0;
        end
        ST_CONFIRM: begin
          if (frame_word) begin
            if (hdr_ok) begin
              good_cnt <= good_cnt + GW'(1);
            end else begin
              good_cnt <= '0;
              miss_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (frame_word) begin
            if (hdr_ok || bad_done) bad_cnt <= '0;
            else                    bad_cnt <= bad_cnt + BW'(1);
            if (!hdr_ok && bad_done) miss_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered with the data so they line up with rx_data_out.
  always_ff @(posedge rx_wordclk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      rx_data_out    <= '0;
      rx_pma_clkslip <= 1'b0;
      frame_start    <= 1'b0;
      header_locked  <= 1'b0;
      header_is_data <= 1'b0;
    end else begin
      rx_data_out    <= rx_parallel_data;
      rx_pma_clkslip <= slip_req;
      frame_start    <= frame_start_nxt;
      header_locked  <= locked_nxt;
      if (!locked_nxt)          header_is_data <= 1'b0;
      else if (frame_start_nxt) header_is_data <= (rx_parallel_data[19:16] == HDR_DATA);
    end
  end

endmodule

// File: tb/tb_gbt_rx_header_aligner.sv
// Randomized bench for gbt_rx_header_aligner: streams are scored against a
// word-index model that jumps search windows and frames instead of clocking states.
module tb_gbt_rx_header_aligner;

  localparam int G    = 64;
  localparam int B    = 4;
  localparam int SW   = 32;
  localparam int MAXN = 1024;

  logic        rx_wordclk = 1'b0;
  logic        rx_reset_n;
  logic        rx_is_lockedtodata;
  logic [19:0] rx_parallel_data;
  logic        rx_pma_clkslip;
  logic [19:0] rx_data_out;
  logic        frame_start;
  logic        header_locked;
  logic        header_is_data;
  logic [4:0]  slip_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] stream [MAXN];
  // {clkslip, frame_start, header_locked, header_is_data, slip_count[4:0], rx_data_out[19:0]}
  logic [28:0] obs    [MAXN];
  logic [28:0] expv   [MAXN];

  gbt_rx_header_aligner #(.GOOD_HEADERS(G), .BAD_HEADERS(B), .SLIP_WAIT(SW)) dut (
    .rx_wordclk        (rx_wordclk),
    .rx_reset_n        (rx_reset_n),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .rx_parallel_data  (rx_parallel_data),
    .rx_pma_clkslip    (rx_pma_clkslip),
    .rx_data_out       (rx_data_out),
    .frame_start       (frame_start),
    .header_locked     (header_locked),
    .header_is_data    (header_is_data),
    .slip_count        (slip_count)
  );

  always #5 rx_wordclk = ~rx_wordclk;

  function automatic bit hdr_ok(input logic [19:0] w);
    return (w[19:16] == 4'b0101) || (w[19:16] == 4'b0110);
  endfunction

  function automatic logic [19:0] bad_word();
    logic [3:0] h;
    h = 4'($urandom_range(0, 15));
    while (h == 4'b0101 || h == 4'b0110) h = 4'($urandom_range(0, 15));
    return {h, 16'($urandom)};
  endfunction

  function automatic logic [19:0] good_word(input bit data_only);
    logic [3:0] h;
    h = (data_only || $urandom_range(0, 1) == 0) ? 4'b0101 : 4'b0110;
    return {h, 16'($urandom)};
  endfunction

  // Invalid headers everywhere except every 6th word from start+off.
  task automatic build_aligned(input int start, input int off, input int n, input bit data_only);
    for (int t = 0; t < n; t++)
      stream[t] = (t >= start && (t - start) % 6 == off) ? good_word(data_only) : bad_word();
  endtask

  // Reference: scan windows of 6 words; a miss costs 6+SW words and one slip,
  // a hit is confirmed by stepping 6 words at a time, lock is tracked per frame.
  task automatic build_expected(input int n);
    bit e_slip [MAXN];
    bit e_fs   [MAXN];
    bit e_lock [MAXN];
    bit e_isd  [MAXN];
    int i, f, j, good, bad, sc;
    for (int t = 0; t < n; t++) begin
      e_slip[t] = 0; e_fs[t] = 0; e_lock[t] = 0; e_isd[t] = 0;
    end
    i = 0;
    while (i < n) begin
      f = -1;
      for (int k = 0; k < 6; k++)
        if (f < 0 && i + k < n && hdr_ok(stream[i + k])) f = i + k;
      if (f < 0) begin
        if (i + 5 < n) e_slip[i + 5] = 1;
        i = i + 6 + SW;
      end else begin
        good = 0;
        j = f;
        while (j < n && good < G && hdr_ok(stream[j])) begin
          good++;
          j += 6;
        end
        if (good < G) begin
          i = j + 1;
        end else begin
          j -= 6;
          bad = 0;
          while (j < n && bad < B) begin
            if (hdr_ok(stream[j])) bad = 0;
            else                   bad++;
            if (bad < B) begin
              e_fs[j] = 1;
              for (int k = j; k < j + 6 && k < n; k++) begin
                e_lock[k] = 1;
                e_isd[k]  = (stream[j][19:16] == 4'b0101);
              end
              j += 6;
            end
          end
          i = j + 1;
        end
      end
    end
    sc = 0;
    for (int t = 0; t < n; t++) begin
      if (e_slip[t]) sc = (sc + 1) % 20;
      expv[t] = {e_slip[t], e_fs[t], e_lock[t], e_isd[t], 5'(sc), stream[t]};
    end
  endtask

  task automatic do_reset();
    rx_reset_n         = 1'b0;
    rx_is_lockedtodata = 1'b0;
    rx_parallel_data   = '0;
    repeat (2) @(posedge rx_wordclk);
    @(negedge rx_wordclk);
    rx_reset_n = 1'b1;
  endtask

  // One IDLE cycle with CDR lock, so stream word 0 is the first searched word.
  task automatic start_search();
    rx_is_lockedtodata = 1'b1;
    @(posedge rx_wordclk);
    #1;
  endtask

  task automatic applyStimulus(input int n);
    for (int t = 0; t < n; t++) begin
      rx_parallel_data = stream[t];
      @(posedge rx_wordclk);
      #1;
      obs[t] = {rx_pma_clkslip, frame_start, header_locked, header_is_data, slip_count, rx_data_out};
    end
  endtask

  function automatic int count_slips(input int n);
    int c = 0;
    for (int t = 0; t < n; t++) if (obs[t][28]) c++;
    return c;
  endfunction

  task automatic test_reset();
    rx_reset_n         = 1'b0;
    rx_is_lockedtodata = 1'b1;
    rx_parallel_data   = 20'($urandom);
    #3;
    n_cmp++; if (rx_pma_clkslip !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_clkslip got=%b want=0", rx_pma_clkslip); end
    n_cmp++; if (frame_start !== 1'b0)    begin n_bad++; $display("[TB] FAIL reset_frame_start got=%b want=0", frame_start); end
    n_cmp++; if (header_locked !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_locked got=%b want=0", header_locked); end
    n_cmp++; if (header_is_data !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_is_data got=%b want=0", header_is_data); end
    n_cmp++; if (slip_count !== 5'd0)     begin n_bad++; $display("[TB] FAIL reset_slip_count got=%0d want=0", slip_count); end
    n_cmp++; if (rx_data_out !== 20'h0)   begin n_bad++; $display("[TB] FAIL reset_data_out got=%h want=0", rx_data_out); end
  endtask

  task automatic test_lock_from_reset();
    int n = 400;
    do_reset();
    build_aligned(0, 2, n, 1'b1);
    build_expected(n);
    start_search();
    applyStimulus(n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs[t] !== expv[t]) begin n_bad++; $display("[TB] FAIL lock_from_reset t=%0d got=%h want=%h", t, obs[t], expv[t]); end
    end
    n_cmp++; if (obs[379][26] !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_early got=%b want=0", obs[379][26]); end
    n_cmp++; if (obs[380][26] !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_at_64 got=%b want=1", obs[380][26]); end
    n_cmp++; if (obs[380][27] !== 1'b1) begin n_bad++; $display("[TB] FAIL first_frame_start got=%b want=1", obs[380][27]); end
    n_cmp++; if (obs[62][27] !== 1'b0)  begin n_bad++; $display("[TB] FAIL confirm_frame_start got=%b want=0", obs[62][27]); end
    n_cmp++; if (obs[380][25] !== 1'b1) begin n_bad++; $display("[TB] FAIL is_data got=%b want=1", obs[380][25]); end
    n_cmp++; if (count_slips(n) !== 0)  begin n_bad++; $display("[TB] FAIL lock_slips got=%0d want=0", count_slips(n)); end
  endtask

  task automatic test_misalignment();
    int r = int'($urandom_range(0, 5));
    int s = 3 * (6 + SW);
    int l = s + r + 6 * (G - 1);
    int n = l + 12;
    do_reset();
    build_aligned(s, r, n, 1'b0);
    build_expected(n);
    start_search();
    applyStimulus(n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs[t] !== expv[t]) begin n_bad++; $display("[TB] FAIL misalign t=%0d got=%h want=%h", t, obs[t], expv[t]); end
    end
    n_cmp++; if (count_slips(n) !== 3)     begin n_bad++; $display("[TB] FAIL misalign_pulses got=%0d want=3", count_slips(n)); end
    n_cmp++; if (obs[n-1][24:20] !== 5'd3) begin n_bad++; $display("[TB] FAIL misalign_slip_count got=%0d want=3", obs[n-1][24:20]); end
    n_cmp++; if (obs[l][26] !== 1'b1)      begin n_bad++; $display("[TB] FAIL misalign_lock got=%b want=1", obs[l][26]); end
  endtask

  task automatic test_false_header();
    int n = 400;
    do_reset();
    build_aligned(8, 0, n, 1'b0);
    stream[0] = good_word(1'b0);
    build_expected(n);
    start_search();
    applyStimulus(n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs[t] !== expv[t]) begin n_bad++; $display("[TB] FAIL false_header t=%0d got=%h want=%h", t, obs[t], expv[t]); end
    end
    n_cmp++; if (count_slips(n) !== 0)  begin n_bad++; $display("[TB] FAIL false_header_slips got=%0d want=0", count_slips(n)); end
    n_cmp++; if (obs[386][26] !== 1'b1) begin n_bad++; $display("[TB] FAIL false_header_lock got=%b want=1", obs[386][26]); end
  endtask

  task automatic test_lock_loss();
    int r = int'($urandom_range(0, 5));
    int l = r + 6 * (G - 1);
    int n = l + 60;
    do_reset();
    build_aligned(0, r, n, 1'b0);
    for (int k = 1; k <= 3; k++) stream[l + 6 * k] = bad_word();
    for (int t = l + 30; t < n; t++) stream[t] = bad_word();
    build_expected(n);
    start_search();
    applyStimulus(n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs[t] !== expv[t]) begin n_bad++; $display("[TB] FAIL lock_loss t=%0d got=%h want=%h", t, obs[t], expv[t]); end
    end
    n_cmp++; if (obs[l+18][26] !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_kept_burst got=%b want=1", obs[l+18][26]); end
    n_cmp++; if (obs[l+42][26] !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_kept_3rd got=%b want=1", obs[l+42][26]); end
    n_cmp++; if (obs[l+48][26] !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_drop_4th got=%b want=0", obs[l+48][26]); end
  endtask

  task automatic test_wrap();
    int n = 21 * (6 + SW);
    do_reset();
    for (int t = 0; t < n; t++) stream[t] = bad_word();
    build_expected(n);
    start_search();
    applyStimulus(n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs[t] !== expv[t]) begin n_bad++; $display("[TB] FAIL wrap t=%0d got=%h want=%h", t, obs[t], expv[t]); end
    end
    n_cmp++; if (obs[5 + 38*18][24:20] !== 5'd19) begin n_bad++; $display("[TB] FAIL wrap_19 got=%0d want=19", obs[5 + 38*18][24:20]); end
    n_cmp++; if (obs[5 + 38*19][24:20] !== 5'd0)  begin n_bad++; $display("[TB] FAIL wrap_0 got=%0d want=0", obs[5 + 38*19][24:20]); end
    n_cmp++; if (count_slips(n) !== 21)           begin n_bad++; $display("[TB] FAIL wrap_pulses got=%0d want=21", count_slips(n)); end
  endtask

  task automatic test_cdr_drop();
    int r = int'($urandom_range(0, 5));
    int s = 3 * (6 + SW);
    int n = s + r + 6 * (G - 1) + 9;
    do_reset();
    build_aligned(s, r, n, 1'b0);
    build_expected(n);
    start_search();
    applyStimulus(n);
    n_cmp++; if (obs[n-1] !== expv[n-1]) begin n_bad++; $display("[TB] FAIL cdr_pre t=%0d got=%h want=%h", n-1, obs[n-1], expv[n-1]); end
    rx_is_lockedtodata = 1'b0;
    rx_parallel_data   = good_word(1'b1);
    @(posedge rx_wordclk);
    #1;
    n_cmp++; if (header_locked !== 1'b0)  begin n_bad++; $display("[TB] FAIL cdr_locked got=%b want=0", header_locked); end
    n_cmp++; if (frame_start !== 1'b0)    begin n_bad++; $display("[TB] FAIL cdr_frame_start got=%b want=0", frame_start); end
    n_cmp++; if (header_is_data !== 1'b0) begin n_bad++; $display("[TB] FAIL cdr_is_data got=%b want=0", header_is_data); end
    n_cmp++; if (slip_count !== 5'd0)     begin n_bad++; $display("[TB] FAIL cdr_slip_count got=%0d want=0", slip_count); end
  endtask

  task automatic test_reset_mid_slip();
    bit seen = 0;
    do_reset();
    start_search();
    for (int c = 0; c < 40 && !seen; c++) begin
      rx_parallel_data = bad_word();
      @(posedge rx_wordclk);
      #1;
      if (rx_pma_clkslip === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("[TB] FAIL slip_pulse_timeout got=none want=pulse within 40 cycles");
    end else begin
      #2;
      rx_reset_n = 1'b0;
      #1;
      n_cmp++; if (rx_pma_clkslip !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mid_slip got=%b want=0", rx_pma_clkslip); end
      n_cmp++; if (slip_count !== 5'd0)     begin n_bad++; $display("[TB] FAIL reset_mid_slip_count got=%0d want=0", slip_count); end
    end
    @(negedge rx_wordclk);
    rx_reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_from_reset();
    test_misalignment();
    test_false_header();
    test_lock_loss();
    test_wrap();
    test_cdr_drop();
    test_reset_mid_slip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("[TB] FAIL watchdog got=timeout want=completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
